// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// Op-code values match the decoder's funct-table entries for HI/LO ops.
package mdu_pkg;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int DIV_ITER  = 32;
    localparam int DIV_CNT_W = $clog2(DIV_ITER);

    typedef enum logic [2:0] {
        MDU_NONE  = OP_NONE,
        MDU_MULT  = OP_MULT,
        MDU_MULTU = OP_MULTU,
        MDU_DIV   = OP_DIV,
        MDU_DIVU  = OP_DIVU,
        MDU_MTHI  = OP_MTHI,
        MDU_MTLO  = OP_MTLO
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } mdu_state_t;

    typedef struct packed {
        logic [31:0] rem;
        logic [31:0] quo;
    } div_step_t;

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and subtract the divisor if it fits.
    function automatic div_step_t divStep(input logic [31:0] rem,
                                          input logic [31:0] quo,
                                          input logic [31:0] divisor);
        logic [32:0] shifted;
        logic [31:0] diff;
        div_step_t   res;
        shifted = {rem, quo[31]};
        diff    = shifted[31:0] - divisor;
        if (shifted >= {1'b0, divisor}) begin
            res.rem = diff;
            res.quo = {quo[30:0], 1'b1};
        end else begin
            res.rem = shifted[31:0];
            res.quo = {quo[30:0], 1'b0};
        end
        return res;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned restoring divider: 32 iterations, the first performed on the
// start edge itself, so done_o marks the cycle of the final iteration.
module mdu_div_core
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    logic [31:0]          rem_q;
    logic [31:0]          quo_q;
    logic [31:0]          divisor_q;
    logic [DIV_CNT_W-1:0] count_q;
    logic                 busy_q;
    div_step_t            startStep;
    div_step_t            runStep;

    assign startStep = divStep(32'd0, dividend_i, divisor_i);
    assign runStep   = divStep(rem_q, quo_q, divisor_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
        end else if (start_i) begin
            rem_q     <= startStep.rem;
            quo_q     <= startStep.quo;
            divisor_q <= divisor_i;
            count_q   <= DIV_CNT_W'(1);
            busy_q    <= 1'b1;
        end else if (busy_q) begin
            rem_q   <= runStep.rem;
            quo_q   <= runStep.quo;
            count_q <= count_q + DIV_CNT_W'(1);
            if (count_q == DIV_CNT_W'(DIV_ITER - 1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done_o      = busy_q && (count_q == DIV_CNT_W'(DIV_ITER - 1));
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the execute stage.
// Optional MDU_DIV_ZERO_FAST_EN: divide by zero skips the iteration phase.
module muldiv_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  mdu_op_t     op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        rd_hilo_i,
    output logic        ready_o,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

`ifdef MDU_DIV_ZERO_FAST_EN
    localparam bit DivZeroFast = 1'b1;
`else
    localparam bit DivZeroFast = 1'b0;
`endif

    localparam logic [1:0] MulCntLast = (MUL_LAT >= 2) ? 2'(MUL_LAT - 2) : 2'd0;

    mdu_state_t  state_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] mulA_q, mulB_q;
    logic        mulSigned_q;
    logic [1:0]  mulCount_q;
    logic        quoNeg_q, remNeg_q, divZero_q;
    logic [31:0] aRaw_q;

    logic        accept, isDivOp, divSigned, divStart;
    logic [31:0] absA, absB;
    logic [31:0] mulSrcA, mulSrcB;
    logic        mulSrcSigned;
    logic [63:0] product_d;
    logic        divDone;
    logic [31:0] quotient, remainder;

    assign ready_o = (state_q == ST_IDLE);
    assign stall_o = !ready_o && (valid_i || rd_hilo_i);
    assign accept  = valid_i && ready_o && (op_i != MDU_NONE);

    assign isDivOp   = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
    assign divSigned = (op_i == MDU_DIV);
    assign absA      = (divSigned && a_i[31]) ? -a_i : a_i;
    assign absB      = (divSigned && b_i[31]) ? -b_i : b_i;
    assign divStart  = accept && isDivOp && !(DivZeroFast && (b_i == 32'd0));

    // With MUL_LAT == 1 the product is written on the accept edge, so the
    // multiplier reads the live operands while idle.
    always_comb begin
        mulSrcA      = mulA_q;
        mulSrcB      = mulB_q;
        mulSrcSigned = mulSigned_q;
        if (state_q == ST_IDLE) begin
            mulSrcA      = a_i;
            mulSrcB      = b_i;
            mulSrcSigned = (op_i == MDU_MULT);
        end
    end

    assign product_d = {{32{mulSrcSigned & mulSrcA[31]}}, mulSrcA} *
                       {{32{mulSrcSigned & mulSrcB[31]}}, mulSrcB};

    mdu_div_core u_div (
        .clk         (clk),
        .reset       (reset),
        .start_i     (divStart),
        .dividend_i  (absA),
        .divisor_i   (absB),
        .done_o      (divDone),
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            mulA_q      <= '0;
            mulB_q      <= '0;
            mulSigned_q <= 1'b0;
            mulCount_q  <= '0;
            quoNeg_q    <= 1'b0;
            remNeg_q    <= 1'b0;
            divZero_q   <= 1'b0;
            aRaw_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (op_i)
                            MDU_MTHI: hi_q <= a_i;
                            MDU_MTLO: lo_q <= a_i;
                            MDU_MULT, MDU_MULTU: begin
                                mulA_q      <= a_i;
                                mulB_q      <= b_i;
                                mulSigned_q <= (op_i == MDU_MULT);
                                mulCount_q  <= '0;
                                if (MUL_LAT == 1) begin
                                    {hi_q, lo_q} <= product_d;
                                end else begin
                                    state_q <= ST_MUL;
                                end
                            end
                            MDU_DIV, MDU_DIVU: begin
                                quoNeg_q  <= divSigned && (a_i[31] != b_i[31]);
                                remNeg_q  <= divSigned && a_i[31];
                                divZero_q <= (b_i == 32'd0);
                                aRaw_q    <= a_i;
                                state_q   <= (DivZeroFast && (b_i == 32'd0)) ? ST_FIX : ST_DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (mulCount_q == MulCntLast) begin
                        {hi_q, lo_q} <= product_d;
                        state_q      <= ST_IDLE;
                    end else begin
                        mulCount_q <= mulCount_q + 2'd1;
                    end
                end
                ST_DIV: begin
                    if (divDone) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // Divide by zero reports the raw dividend with no sign fix.
                    if (divZero_q) begin
                        lo_q <= 32'hFFFF_FFFF;
                        hi_q <= aRaw_q;
                    end else begin
                        lo_q <= quoNeg_q ? -quotient : quotient;
                        hi_q <= remNeg_q ? -remainder : remainder;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl with hand-computed results.
module tb_muldiv_ctrl;
    import mdu_pkg::*;

`ifdef MDU_DIV_ZERO_FAST_EN
    localparam int DivZeroTicks = 1;
`else
    localparam int DivZeroTicks = 32;
`endif

    logic        clk;
    logic        reset;
    logic        valid;
    mdu_op_t     op;
    logic [31:0] a, b;
    logic        rdHilo;
    logic        ready, stall;
    logic [31:0] hi, lo;
    int          total;
    int          bad;

    muldiv_ctrl #(.MUL_LAT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid),
        .op_i      (op),
        .a_i       (a),
        .b_i       (b),
        .rd_hilo_i (rdHilo),
        .ready_o   (ready),
        .stall_o   (stall),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input mdu_op_t o, input logic [31:0] av,
                                 input logic [31:0] bv, input logic rd);
        valid  = v;
        op     = o;
        a      = av;
        b      = bv;
        rdHilo = rd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        checkOutput("reset_ready", {31'd0, ready}, 32'd1);
        checkOutput("reset_stall", {31'd0, stall}, 32'd0);

        // NONE with valid is ignored
        applyStimulus(1'b1, MDU_NONE, 32'h55, 32'h66, 1'b0);
        tick();
        checkOutput("none_ready", {31'd0, ready}, 32'd1);
        checkOutput("none_lo", lo, 32'd0);

        // MULTU all-ones squared: one busy cycle, result on the second edge
        applyStimulus(1'b1, MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        tick();
        applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0, 1'b0);
        checkOutput("multu_busy_ready", {31'd0, ready}, 32'd0);
        checkOutput("multu_early_lo", lo, 32'd0);
        tick();
        checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
        checkOutput("multu_lo", lo, 32'h0000_0001);
        checkOutput("multu_ready", {31'd0, ready}, 32'd1);

        // MULT -3 * 5, back-to-back
        applyStimulus(1'b1, MDU_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
        tick();
        applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0, 1'b0);
        tick();
        checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo, 32'hFFFF_FFF1);

        // DIV -7 / 2 with MFHI/MFLO waiting the whole time
        applyStimulus(1'b1, MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        checkOutput("div_accept_stall", {31'd0, stall}, 32'd0);
        tick();
        applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0, 1'b1);
        for (int i = 1; i <= 32; i++) begin
            checkOutput($sformatf("div_stall_c%0d", i), {31'd0, stall}, 32'd1);
            if (i == 32) checkOutput("div_early_lo", lo, 32'hFFFF_FFF1);
            tick();
        end
        checkOutput("div_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_hi", hi, 32'hFFFF_FFFF);
        checkOutput("div_done_stall", {31'd0, stall}, 32'd0);
        checkOutput("div_done_ready", {31'd0, ready}, 32'd1);

        // DIVU 100 / 7 with an MTHI held off while busy
        applyStimulus(1'b1, MDU_DIVU, 32'd100, 32'd7, 1'b0);
        tick();
        applyStimulus(1'b1, MDU_MTHI, 32'h1234, 32'd0, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            checkOutput($sformatf("divu_stall_c%0d", i), {31'd0, stall}, 32'd1);
            tick();
        end
        checkOutput("divu_lo", lo, 32'd14);
        checkOutput("divu_hi", hi, 32'd2);
        checkOutput("divu_mthi_stall", {31'd0, stall}, 32'd0);
        tick();
        applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0, 1'b0);
        checkOutput("mthi_hi", hi, 32'h1234);
        checkOutput("mthi_lo", lo, 32'd14);

        // INT_MIN / -1 wraps
        applyStimulus(1'b1, MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        tick();
        applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 32; i++) tick();
        checkOutput("intmin_lo", lo, 32'h8000_0000);
        checkOutput("intmin_hi", hi, 32'd0);

        // DIV by zero
        applyStimulus(1'b1, MDU_DIV, 32'h8000_0000, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0, 1'b0);
        for (int i = 1; i <= DivZeroTicks; i++) begin
            checkOutput($sformatf("div0_busy_c%0d", i), {31'd0, ready}, 32'd0);
            tick();
        end
        checkOutput("div0_lo", lo, 32'hFFFF_FFFF);
        checkOutput("div0_hi", hi, 32'h8000_0000);
        checkOutput("div0_ready", {31'd0, ready}, 32'd1);

        // reset during division iteration 10
        applyStimulus(1'b1, MDU_DIV, 32'd1000, 32'd3, 1'b0);
        tick();
        applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midrst_hi", hi, 32'd0);
        checkOutput("midrst_lo", lo, 32'd0);
        checkOutput("midrst_ready", {31'd0, ready}, 32'd1);
        checkOutput("midrst_stall", {31'd0, stall}, 32'd0);
        applyStimulus(1'b1, MDU_MTLO, 32'd5, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0, 1'b0);
        checkOutput("mtlo_lo", lo, 32'd5);
        checkOutput("mtlo_hi", hi, 32'd0);
        checkOutput("mtlo_ready", {31'd0, ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
